// File: rtl/vend_dispense_ctrl.sv
// Purpose : queues drink/change orders from the vending FSM and sequences the dispense actuators.
// Latency : an order pushed into an empty queue while idle starts its motor on the next edge.
// Backpressure: none upstream; an order arriving at a full queue is dropped, pulsed and counted.

// Purpose : generic single-clock FIFO with wrap-around pointers and a separate occupancy count.
// Latency : pushed data is readable at the head one edge after the push; the head is combinational.
// Backpressure: none internally; the caller must not push when full (unless popping) or pop when empty.
module vend_job_fifo #(
   parameter int WIDTH  = 2,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [WIDTH-1:0]  push_dat,
   input  logic              pop,
   output logic [WIDTH-1:0]  pop_dat,
   output logic [ADDR_W:0]   level
);

   localparam logic [ADDR_W:0]   LVL_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   assign pop_dat = mem[rd_ptr];

   // Storage array: written on push, no reset needed since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// Purpose : dispense sequencer: one job at a time through VEND, optional EJECT, then a settle GAP.
// Latency : motor rises one edge after the pop; drink VEND_CYC, eject EJECT_CYC, settle GAP_CYC cycles.
// Backpressure: upstream never stalls; jobs beyond DEPTH are dropped with an overflow pulse.
module vend_dispense_ctrl #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 2,
   parameter int VEND_CYC  = 8,
   parameter int EJECT_CYC = 4,
   parameter int GAP_CYC   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        drinks_in,
   input  logic              change_in,
   output logic              motor_a,
   output logic              motor_b,
   output logic              coin_eject,
   output logic              busy,
   output logic [ADDR_W:0]   q_level,
   output logic              overflow,
   output logic [7:0]        drop_cnt
);

   // Timer only ever holds (longest phase - 1), so log2 of the longest phase is enough.
   localparam int T_VE   = (VEND_CYC > EJECT_CYC) ? VEND_CYC : EJECT_CYC;
   localparam int T_MAX  = (T_VE > GAP_CYC) ? T_VE : GAP_CYC;
   localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_ONE = 1;
   localparam logic [TMR_W-1:0] TMR_VEND  = TMR_W'(VEND_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_EJECT = TMR_W'(EJECT_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_VEND  = 2'd1,
      S_EJECT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic             job_type;    // 0 = 5$ drink (motor_a), 1 = 10$ drink (motor_b)
   logic             job_chg;     // change owed after the drink

   logic             push_req;
   logic             push_ok;
   logic             gap_done;
   logic             pop;
   logic [1:0]       head;

   // Only codes 1 and 2 are orders; 0 and the illegal 3 are ignored together with change_in.
   assign push_req = (drinks_in == 2'd1) || (drinks_in == 2'd2);

   // The last GAP cycle behaves as IDLE so back-to-back jobs run at VEND+GAP spacing.
   assign gap_done = (state == S_GAP) && (timer == '0);
   assign pop      = ((state == S_IDLE) || gap_done) && (q_level != '0);

   // A full queue still accepts an order on the edge that frees a slot.
   assign push_ok  = push_req && ((q_level < LVL_FULL) || pop);

   vend_job_fifo #(
      .WIDTH  (2),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_job_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_ok),
      .push_dat ({drinks_in[1], change_in}),
      .pop      (pop),
      .pop_dat  (head),
      .level    (q_level)
   );

   // Drop reporting: one-cycle overflow pulse and a saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         overflow <= push_req && !push_ok;
         if (push_req && !push_ok && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   // Dispense FSM; actuator and busy outputs are registered from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         timer      <= '0;
         job_type   <= 1'b0;
         job_chg    <= 1'b0;
         motor_a    <= 1'b0;
         motor_b    <= 1'b0;
         coin_eject <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_GAP: begin
               if ((state == S_GAP) && (timer != '0)) begin
                  timer <= timer - TMR_ONE;
               end else if (pop) begin
                  state      <= S_VEND;
                  timer      <= TMR_VEND;
                  job_type   <= head[1];
                  job_chg    <= head[0];
                  motor_a    <= ~head[1];
                  motor_b    <= head[1];
                  coin_eject <= 1'b0;
                  busy       <= 1'b1;
               end else begin
                  state      <= S_IDLE;
                  motor_a    <= 1'b0;
                  motor_b    <= 1'b0;
                  coin_eject <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            S_VEND: begin
               if (timer != '0) begin
                  timer   <= timer - TMR_ONE;
                  motor_a <= ~job_type;
                  motor_b <= job_type;
               end else if (job_chg) begin
                  state      <= S_EJECT;
                  timer      <= TMR_EJECT;
                  motor_a    <= 1'b0;
                  motor_b    <= 1'b0;
                  coin_eject <= 1'b1;
               end else begin
                  state      <= S_GAP;
                  timer      <= TMR_GAP;
                  motor_a    <= 1'b0;
                  motor_b    <= 1'b0;
                  coin_eject <= 1'b0;
               end
            end
            S_EJECT: begin
               if (timer != '0) begin
                  timer <= timer - TMR_ONE;
               end else begin
                  state      <= S_GAP;
                  timer      <= TMR_GAP;
                  coin_eject <= 1'b0;
               end
            end
            default: begin
               state      <= S_IDLE;
               motor_a    <= 1'b0;
               motor_b    <= 1'b0;
               coin_eject <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
